// File: rtl/i2c_types.sv
// Shared I2C types: controller transaction kind and the poll sequencer state encoding.
package i2c_types;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_transaction_t;

    typedef enum logic [2:0] {
        S_WAIT     = 3'd0,
        S_PTR_REQ  = 3'd1,
        S_PTR_WAIT = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_DONE     = 3'd5
    } poll_state_t;

    // States during which a controller transaction is outstanding and the timeout runs.
    function automatic logic is_xfer_state(input poll_state_t s);
        return (s == S_PTR_REQ) || (s == S_PTR_WAIT) || (s == S_RD_REQ) || (s == S_RD_WAIT);
    endfunction

endpackage

// File: rtl/i2c_poll_sequencer.sv
// Periodic I2C register poller: writes a register pointer, reads NUM_BYTES one at a time,
// and publishes the whole burst atomically.
//   state      | meaning
//   S_WAIT     | idle, period counter running
//   S_PTR_REQ  | request pointer write
//   S_PTR_WAIT | pointer write in flight (ready low then high)
//   S_RD_REQ   | request one byte read
//   S_RD_WAIT  | byte read in flight
//   S_DONE     | publish shadow buffer, pulse rd_valid
module i2c_poll_sequencer
    import i2c_types::*;
#(
    parameter int         CLK_HZ             = 12_000_000,
    parameter int         POLL_PERIOD_CYCLES = 120_000,
    parameter logic [6:0] TARGET_ADDR        = 7'h38,
    parameter logic [7:0] START_REG          = 8'h00,
    parameter int         NUM_BYTES          = 4,
    parameter int         TIMEOUT_CYCLES     = 24_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     ctl_i_ready,
    output logic                     ctl_i_valid,
    output i2c_transaction_t         ctl_mode,
    output logic [6:0]               ctl_i_addr,
    output logic [7:0]               ctl_i_data,
    input  logic                     ctl_o_valid,
    input  logic [7:0]               ctl_o_data,
    output logic [8*NUM_BYTES-1:0]   rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     err
);

    localparam int PER_W = $clog2(POLL_PERIOD_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int IDX_W = $clog2(NUM_BYTES) + 1;
    localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(POLL_PERIOD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BYTES - 1);

    if (NUM_BYTES < 1 || NUM_BYTES > 16 || CLK_HZ <= 0 ||
        POLL_PERIOD_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("i2c_poll_sequencer: parameter out of range");
    end

    poll_state_t              r_state;
    logic [PER_W-1:0]         r_period;
    logic [TMO_W-1:0]         r_tmo;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_seen_low;
    logic                     r_valid;
    i2c_transaction_t         r_mode;
    logic [7:0]               r_data;
    logic [8*NUM_BYTES-1:0]   r_shadow;
    logic [8*NUM_BYTES-1:0]   r_rd_data;
    logic                     r_rd_valid;
    logic                     r_err;

    logic w_period_zero, w_in_xfer, w_is_req, w_accept, w_wait_done, w_progress, w_abort;

    assign w_period_zero = (r_period == '0);
    assign w_in_xfer     = is_xfer_state(r_state);
    assign w_is_req      = (r_state == S_PTR_REQ) || (r_state == S_RD_REQ);
    assign w_accept      = r_valid & ctl_i_ready;
    assign w_wait_done   = r_seen_low & ctl_i_ready;
    assign w_progress    = w_is_req ? w_accept : w_wait_done;
    // A read that completes without valid data is handled exactly like an expiry.
    assign w_abort       = (w_in_xfer && r_tmo == '0 && !w_progress) ||
                           (r_state == S_RD_WAIT && w_wait_done && !ctl_o_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT;
            r_period   <= PER_RELOAD;
            r_tmo      <= '0;
            r_idx      <= '0;
            r_seen_low <= 1'b0;
            r_valid    <= 1'b0;
            r_mode     <= I2C_WRITE;
            r_data     <= '0;
            r_shadow   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            // Free-running grid: a boundary hit while busy (or disabled) is simply dropped.
            r_period   <= w_period_zero ? PER_RELOAD : r_period - 1'b1;
            if (w_in_xfer && r_tmo != '0) r_tmo <= r_tmo - 1'b1;

            if (w_abort) begin
                r_state <= S_WAIT;
                r_valid <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_WAIT: if (w_period_zero && ena) begin
                        r_state <= S_PTR_REQ;
                        r_valid <= 1'b1;
                        r_mode  <= I2C_WRITE;
                        r_data  <= START_REG;
                        r_tmo   <= TMO_RELOAD;
                    end
                    S_PTR_REQ, S_RD_REQ: if (w_accept) begin
                        r_state    <= (r_state == S_PTR_REQ) ? S_PTR_WAIT : S_RD_WAIT;
                        r_valid    <= 1'b0;
                        r_seen_low <= 1'b0;
                    end
                    S_PTR_WAIT, S_RD_WAIT: if (w_wait_done) begin
                        if (r_state == S_RD_WAIT) begin
                            for (int k = 0; k < NUM_BYTES; k++)
                                if (r_idx == IDX_W'(k)) r_shadow[8*k +: 8] <= ctl_o_data;
                        end
                        if (r_state == S_RD_WAIT && r_idx >= IDX_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= (r_state == S_PTR_WAIT) ? '0 : r_idx + 1'b1;
                            r_state <= S_RD_REQ;
                            r_valid <= 1'b1;
                            r_mode  <= I2C_READ;
                            r_tmo   <= TMO_RELOAD;
                        end
                    end else if (!ctl_i_ready) begin
                        r_seen_low <= 1'b1;
                    end
                    S_DONE: begin
                        r_rd_data  <= r_shadow;
                        r_rd_valid <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                    default: r_state <= S_WAIT;
                endcase
            end
        end
    end

    assign ctl_i_valid = r_valid;
    assign ctl_mode    = r_mode;
    assign ctl_i_addr  = TARGET_ADDR;
    assign ctl_i_data  = r_data;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign busy        = (r_state != S_WAIT);
    assign err         = r_err;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: channel 0 (period 1000) runs a vector table and corner
// sequences; channel 1 (period 200, slow controller) exercises skipped periods.
module tb_i2c_poll_sequencer;
    import i2c_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ena      [2];
    logic       m_accept [2];
    int         m_lat    [2];
    logic [7:0] m_base   [2];
    logic [7:0] m_fail   [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             valid, ready, ov, rdv, busy, err;
        i2c_transaction_t mode;
        logic [6:0]       addr;
        logic [7:0]       data, od;
        logic [31:0]      rd_data;
        logic             mready;
        int               mcnt;
        logic [7:0]       rd_n;
        int wr_cnt = 0, rd_cnt = 0, field_bad = 0, vc_cnt = 0, rdv_cnt = 0, err_cnt = 0;

        assign ready = mready & m_accept[g];

        i2c_poll_sequencer #(
            .CLK_HZ            (12_000_000),
            .POLL_PERIOD_CYCLES(g == 0 ? 1000 : 200),
            .TARGET_ADDR       (7'h38),
            .START_REG         (8'h00),
            .NUM_BYTES         (4),
            .TIMEOUT_CYCLES    (200)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .ena        (ena[g]),
            .ctl_i_ready(ready),
            .ctl_i_valid(valid),
            .ctl_mode   (mode),
            .ctl_i_addr (addr),
            .ctl_i_data (data),
            .ctl_o_valid(ov),
            .ctl_o_data (od),
            .rd_data    (rd_data),
            .rd_valid   (rdv),
            .busy       (busy),
            .err        (err)
        );

        // Controller model: ready drops after accept, returns m_lat cycles later; read n -> base+n.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mready <= 1'b1;
                mcnt   <= 0;
                ov     <= 1'b0;
                od     <= 8'h00;
                rd_n   <= 8'h00;
            end else if (mcnt != 0) begin
                if (mcnt == 1) mready <= 1'b1;
                mcnt <= mcnt - 1;
            end else if (valid && ready) begin
                mready <= 1'b0;
                mcnt   <= m_lat[g];
                if (mode == I2C_WRITE) begin
                    wr_cnt <= wr_cnt + 1;
                    rd_n   <= 8'h00;
                    if (data != 8'h00 || addr != 7'h38) field_bad <= field_bad + 1;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                    od     <= m_base[g] + rd_n;
                    ov     <= (rd_n != m_fail[g]);
                    rd_n   <= rd_n + 8'h01;
                    if (addr != 7'h38) field_bad <= field_bad + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (valid) vc_cnt  <= vc_cnt + 1;
            if (rdv)   rdv_cnt <= rdv_cnt + 1;
            if (err)   err_cnt <= err_cnt + 1;
        end
    end

    typedef struct {
        logic        ena;
        logic        acc;
        logic [7:0]  base;
        logic [7:0]  fail;
        int          wr;
        int          rd;
        int          vc;
        int          rdv;
        int          er;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   64'(g_ch[0].valid),   64'd0);
        check({tag, "_mode"},    64'(g_ch[0].mode),    64'(I2C_WRITE));
        check({tag, "_addr"},    64'(g_ch[0].addr),    64'h38);
        check({tag, "_data"},    64'(g_ch[0].data),    64'd0);
        check({tag, "_rd_data"}, 64'(g_ch[0].rd_data), 64'd0);
        check({tag, "_rd_valid"},64'(g_ch[0].rdv),     64'd0);
        check({tag, "_busy"},    64'(g_ch[0].busy),    64'd0);
        check({tag, "_err"},     64'(g_ch[0].err),     64'd0);
    endtask

    initial begin
        int n, s_wr, s_rd, s_vc, s_rdv, s_err;

        ena      = '{1'b0, 1'b0};
        m_accept = '{1'b1, 1'b1};
        m_lat    = '{50, 100};
        m_base   = '{8'hA0, 8'h40};
        m_fail   = '{8'hFF, 8'hFF};

        //           ena   acc   base   fail   wr rd vc  rdv er  rd_data
        vecs[0] = '{1'b1, 1'b1, 8'hA0, 8'hFF, 1, 4, 5,   1, 0, 32'hA3A2A1A0};
        vecs[1] = '{1'b0, 1'b1, 8'hA0, 8'hFF, 0, 0, 0,   0, 0, 32'hA3A2A1A0};
        vecs[2] = '{1'b0, 1'b1, 8'hA0, 8'hFF, 0, 0, 0,   0, 0, 32'hA3A2A1A0};
        vecs[3] = '{1'b0, 1'b1, 8'hA0, 8'hFF, 0, 0, 0,   0, 0, 32'hA3A2A1A0};
        vecs[4] = '{1'b1, 1'b1, 8'hB0, 8'h02, 1, 3, 4,   0, 1, 32'hA3A2A1A0};
        vecs[5] = '{1'b1, 1'b1, 8'hB0, 8'hFF, 1, 4, 5,   1, 0, 32'hB3B2B1B0};
        vecs[6] = '{1'b1, 1'b0, 8'hC0, 8'hFF, 0, 0, 200, 0, 1, 32'hB3B2B1B0};
        vecs[7] = '{1'b1, 1'b1, 8'hC0, 8'hFF, 1, 4, 5,   1, 0, 32'hC3C2C1C0};
        vecs[8] = '{1'b1, 1'b1, 8'h10, 8'h00, 1, 1, 2,   0, 1, 32'hC3C2C1C0};
        vecs[9] = '{1'b1, 1'b1, 8'hF0, 8'h03, 1, 4, 5,   0, 1, 32'hC3C2C1C0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        ena[0] = 1'b1;
        rst    = 1'b0;
        n = 0;
        while (g_ch[0].valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("first_poll_latency", 64'(n), 64'd1000);
        repeat (500) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            ena[0]      = vecs[i].ena;
            m_accept[0] = vecs[i].acc;
            m_base[0]   = vecs[i].base;
            m_fail[0]   = vecs[i].fail;
            s_wr  = g_ch[0].wr_cnt;
            s_rd  = g_ch[0].rd_cnt;
            s_vc  = g_ch[0].vc_cnt;
            s_rdv = g_ch[0].rdv_cnt;
            s_err = g_ch[0].err_cnt;
            repeat (1000) @(negedge clk);
            check($sformatf("v%0d_writes", i),   64'(g_ch[0].wr_cnt - s_wr),   64'(vecs[i].wr));
            check($sformatf("v%0d_reads", i),    64'(g_ch[0].rd_cnt - s_rd),   64'(vecs[i].rd));
            check($sformatf("v%0d_req_cyc", i),  64'(g_ch[0].vc_cnt - s_vc),   64'(vecs[i].vc));
            check($sformatf("v%0d_rd_valid", i), 64'(g_ch[0].rdv_cnt - s_rdv), 64'(vecs[i].rdv));
            check($sformatf("v%0d_err", i),      64'(g_ch[0].err_cnt - s_err), 64'(vecs[i].er));
            check($sformatf("v%0d_rd_data", i),  64'(g_ch[0].rd_data),         64'(vecs[i].data));
        end

        // Never-accepting controller: err exactly 200 cycles after the request, retry a period later.
        m_accept[0] = 1'b0;
        m_fail[0]   = 8'hFF;
        s_rdv = g_ch[0].rdv_cnt;
        n = 0;
        while (g_ch[0].valid !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
        n = 0;
        while (g_ch[0].err !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("timeout_err_delay", 64'(n), 64'd200);
        n = 0;
        while (g_ch[0].valid !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
        check("retry_after_timeout", 64'(n), 64'd800);
        check("timeout_no_rd_valid", 64'(g_ch[0].rdv_cnt - s_rdv), 64'd0);

        // Reset while the second read is in flight.
        m_accept[0] = 1'b1;
        m_base[0]   = 8'h66;
        s_rd = g_ch[0].rd_cnt;
        n = 0;
        while (g_ch[0].rd_cnt - s_rd < 2 && n < 400) begin @(negedge clk); n++; end
        check("second_read_reached", 64'(g_ch[0].rd_cnt - s_rd), 64'd2);
        repeat (5) @(negedge clk);
        check("busy_before_reset", 64'(g_ch[0].busy), 64'd1);
        s_rdv = g_ch[0].rdv_cnt;
        s_err = g_ch[0].err_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        m_base[0] = 8'h55;
        rst = 1'b0;
        n = 0;
        while (g_ch[0].valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("post_reset_latency", 64'(n), 64'd1000);
        check("reset_no_rd_valid", 64'(g_ch[0].rdv_cnt - s_rdv), 64'd0);
        check("reset_no_err",      64'(g_ch[0].err_cnt - s_err), 64'd0);

        // Dropping ena mid-poll lets the burst finish.
        ena[0] = 1'b0;
        n = 0;
        while (g_ch[0].rdv !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("ena_drop_rd_valid", 64'(g_ch[0].rdv), 64'd1);
        check("ena_drop_rd_data",  64'(g_ch[0].rd_data), 64'h58575655);
        s_vc = g_ch[0].vc_cnt;
        repeat (1000) @(negedge clk);
        check("ena_low_no_requests", 64'(g_ch[0].vc_cnt - s_vc), 64'd0);

        // Slow controller on channel 1: poll spans 3 periods, two boundaries are skipped.
        ena[1] = 1'b1;
        s_wr = g_ch[1].wr_cnt;
        n = 0;
        while (g_ch[1].wr_cnt == s_wr && n < 400) begin @(negedge clk); n++; end
        s_wr  = g_ch[1].wr_cnt;
        s_rdv = g_ch[1].rdv_cnt;
        n = 0;
        while (g_ch[1].wr_cnt == s_wr && n < 1500) begin @(negedge clk); n++; end
        check("skip_poll_interval", 64'(n), 64'd600);
        check("skip_one_rd_valid",  64'(g_ch[1].rdv_cnt - s_rdv), 64'd1);
        check("skip_rd_data",       64'(g_ch[1].rd_data), 64'h43424140);

        check("ch0_request_fields", 64'(g_ch[0].field_bad), 64'd0);
        check("ch1_request_fields", 64'(g_ch[1].field_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_poll_sequencer.md
I2C_POLL_SEQUENCER -- requirements
Module: i2c_poll_sequencer

Interface
REQ-001 SHALL take parameter CLK_HZ, default 12_000_000, system clock frequency.
REQ-002 SHALL take parameter POLL_PERIOD_CYCLES, default 120_000, cycles between poll starts (10 ms).
REQ-003 SHALL take parameter TARGET_ADDR, default 7'h38, 7-bit target address.
REQ-004 SHALL take parameter START_REG, default 8'h00, first register index.
REQ-005 SHALL take parameter NUM_BYTES, default 4, range 1..16, bytes read per poll.
REQ-006 SHALL take parameter TIMEOUT_CYCLES, default 24_000, max cycles per controller transaction.
REQ-007 SHALL have these ports; clock and reset first:
  clk  in  1  system clock.
  rst  in  1  reset.
  ena  in  1  polling enable.
  ctl_i_ready  in  1  controller idle/accepting.
  ctl_i_valid  out  1  transaction request to controller.
  ctl_mode  out  i2c_transaction_t  WRITE or READ.
  ctl_i_addr  out  7  target address.
  ctl_i_data  out  8  write byte.
  ctl_o_valid  in  1  controller read data valid.
  ctl_o_data  in  8  controller read byte.
  rd_data  out  8*NUM_BYTES  last completed burst; byte k at [8k+7:8k].
  rd_valid  out  1  one-cycle pulse: rd_data updated.
  busy  out  1  poll in progress.
  err  out  1  one-cycle pulse: transaction timed out.
REQ-008 SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-009 SHALL implement states S_WAIT, S_PTR_REQ, S_PTR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE.
REQ-010 S_WAIT SHALL decrement the period counter; the FSM SHALL go to S_PTR_REQ when the counter is 0 and ena=1; the counter SHALL reload to POLL_PERIOD_CYCLES-1 on that transition.
REQ-011 ena=0 SHALL only block new polls; an in-progress poll SHALL run to S_DONE or timeout.
REQ-012 S_PTR_REQ SHALL drive ctl_i_valid=1, ctl_mode=WRITE, ctl_i_addr=TARGET_ADDR, ctl_i_data=START_REG until the cycle where ctl_i_valid&ctl_i_ready=1, then go to S_PTR_WAIT.
REQ-013 S_PTR_WAIT SHALL wait for ctl_i_ready to go low, then high again; on that high cycle it SHALL go to S_RD_REQ with the byte index set to 0.
REQ-014 S_RD_REQ SHALL drive ctl_i_valid=1, ctl_mode=READ, ctl_i_addr=TARGET_ADDR until accepted, then go to S_RD_WAIT.
REQ-015 S_RD_WAIT SHALL complete on the same low-then-high ctl_i_ready sequence as S_PTR_WAIT.
REQ-016 On S_RD_WAIT completion, the FSM SHALL write ctl_o_data into the shadow buffer at the byte index, provided ctl_o_valid=1.
REQ-017 On S_RD_WAIT completion, if the byte index is less than NUM_BYTES-1, the FSM SHALL increment the index and return to S_RD_REQ; otherwise it SHALL go to S_DONE.
REQ-018 S_DONE SHALL copy the shadow buffer to rd_data, pulse rd_valid for exactly 1 cycle, and go to S_WAIT.
REQ-019 rd_data SHALL change only in S_DONE, so a partial burst is never visible.
REQ-020 ctl_i_valid SHALL be 0 in all states except *_REQ.
REQ-021 ctl_i_valid SHALL be registered, with no combinational path from ctl_i_ready.
REQ-022 busy SHALL be 1 in every state except S_WAIT.
REQ-023 A timeout counter SHALL reload to TIMEOUT_CYCLES-1 on entry to each *_REQ state and decrement in *_REQ/*_WAIT states.
REQ-024 On timeout expiry, the FSM SHALL pulse err for 1 cycle, go to S_WAIT, leave rd_data unchanged, and not assert rd_valid.
REQ-025 If ctl_o_valid=0 at read completion, the FSM SHALL treat it as a timeout (err pulse, abort).
REQ-026 If the period counter reaches 0 while busy, that poll SHALL be skipped, not queued.
REQ-027 Counter widths SHALL be $clog2(param)+1; the byte index SHALL be $clog2(NUM_BYTES)+1 bits, and no counter SHALL wrap.

Reset
REQ-028 rst SHALL force: state=S_WAIT, period counter=POLL_PERIOD_CYCLES-1, timeout counter=0, byte index=0, ctl_i_valid=0, ctl_mode=WRITE, ctl_i_addr=TARGET_ADDR, ctl_i_data=0, rd_data=0, rd_valid=0, busy=0, err=0.
REQ-029 rst asserted mid-transaction SHALL abort immediately with no rd_valid or err pulse; the first poll after release SHALL occur POLL_PERIOD_CYCLES cycles later.

Structure
REQ-030 The state enum (poll_state_t) SHALL live in the shared i2c_types package; i2c_transaction_t SHALL be reused from that package.
REQ-031 SHALL contain no sub-module; a separate top-level test wrapper SHALL instantiate this block plus i2c_controller.

Verification
REQ-032 Behavioural controller model (ready drops 1 cycle after accept, returns after 50 cycles, reads return 8'hA0+n), ena=1, POLL_PERIOD_CYCLES=1000 -> 1 WRITE of 8'h00 to 7'h38, then 4 READs; rd_data=32'hA3A2A1A0; one rd_valid pulse.
REQ-033 Model never accepts (ctl_i_ready=0), TIMEOUT_CYCLES=200 -> err pulses 200 cycles after entering S_PTR_REQ; rd_valid=0; next attempt one period later.
REQ-034 Third READ returns ctl_o_valid=0 -> err pulse; rd_data keeps the prior burst value.
REQ-035 Assert rst during the second READ -> all outputs at reset values the next cycle; no rd_valid pulse.
REQ-036 ena=0 for 3 periods -> zero ctl_i_valid assertions; ena dropped mid-poll -> burst still completes with rd_valid=1.
REQ-037 Model completion latency > POLL_PERIOD_CYCLES -> the overlapping period is skipped, with exactly one poll in flight at any time.
